// File: rtl/fetch_pc_unit.sv
// Fetch-address / PC stage: selects the next instruction address, flushes the
// wrong-path instruction after a redirect, and flags misaligned taken targets.
module fetch_pc_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BRANCH_TAKEN,
    input  logic [4:0]  OPCODE_6_TO_2,
    input  logic [31:0] IADDER_OUT,
    input  logic        TRAP_TAKEN,
    input  logic [31:0] TRAP_ADDRESS,
    input  logic        PC_STALL,
    input  logic        I_READY,
    output logic [31:0] I_ADDR,
    output logic        I_REQ,
    output logic [31:0] PC,
    output logic        FLUSH,
    output logic        MISALIGNED_INSTR,
    output logic [1:0]  DBG_STATE
);

    localparam logic [4:0] OPCODE_JALR = 5'b11001;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] i_addr_q, i_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;
    logic        i_req_q;

    logic        is_jalr;
    logic [31:0] target;
    logic        advance;
    logic        branch_ok;

    assign is_jalr   = (OPCODE_6_TO_2 == OPCODE_JALR);
    assign target    = {IADDER_OUT[31:1], IADDER_OUT[0] & ~is_jalr};
    assign advance   = (state_q != BOOT) & I_READY & ~PC_STALL;
    // A bubble cannot branch, and a stalled stage is not allowed to redirect.
    assign branch_ok = BRANCH_TAKEN & ~flush_q & ~PC_STALL;

    always_comb begin
        i_addr_d     = i_addr_q;
        pc_d         = pc_q;
        flush_d      = flush_q;
        misaligned_d = 1'b0;
        if (state_q != BOOT) begin
            if (TRAP_TAKEN) begin
                i_addr_d = TRAP_ADDRESS & ~32'h3;
                flush_d  = 1'b1;
            end else if (branch_ok && !target[1]) begin
                i_addr_d = target & ~32'h3;
                flush_d  = 1'b1;
            end else begin
                // Misaligned target: no redirect, the trap unit takes over.
                misaligned_d = branch_ok;
                if (advance) begin
                    pc_d     = i_addr_q;
                    i_addr_d = i_addr_q + 32'd4;
                    flush_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= BOOT;
            i_addr_q     <= {BOOT_ADDRESS[31:2], 2'b00};
            pc_q         <= 32'h0;
            flush_q      <= 1'b1;
            misaligned_q <= 1'b0;
            i_req_q      <= 1'b0;
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                default: state_q <= advance ? RUN : HOLD;
            endcase
            i_addr_q     <= i_addr_d;
            pc_q         <= pc_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
            i_req_q      <= 1'b1;
        end
    end

    assign I_ADDR           = i_addr_q;
    assign I_REQ            = i_req_q;
    assign PC               = pc_q;
    assign FLUSH            = flush_q;
    assign MISALIGNED_INSTR = misaligned_q;
    assign DBG_STATE        = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed test-plan steps followed by randomized
// traffic, every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam logic [31:0] BOOT = 32'h0000_0100;
    localparam logic [4:0]  JALR = 5'b11001;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BRANCH_TAKEN;
    logic [4:0]  OPCODE_6_TO_2;
    logic [31:0] IADDER_OUT;
    logic        TRAP_TAKEN;
    logic [31:0] TRAP_ADDRESS;
    logic        PC_STALL;
    logic        I_READY;
    logic [31:0] I_ADDR;
    logic        I_REQ;
    logic [31:0] PC;
    logic        FLUSH;
    logic        MISALIGNED_INSTR;
    logic [1:0]  DBG_STATE;

    int checks = 0;
    int errors = 0;

    // Reference model of the architecturally visible stage contents.
    logic        m_booting;
    logic [31:0] m_iaddr;
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_mis;

    fetch_pc_unit #(.BOOT_ADDRESS(BOOT)) dut (
        .CLK(CLK), .RESET(RESET), .BRANCH_TAKEN(BRANCH_TAKEN),
        .OPCODE_6_TO_2(OPCODE_6_TO_2), .IADDER_OUT(IADDER_OUT),
        .TRAP_TAKEN(TRAP_TAKEN), .TRAP_ADDRESS(TRAP_ADDRESS),
        .PC_STALL(PC_STALL), .I_READY(I_READY), .I_ADDR(I_ADDR),
        .I_REQ(I_REQ), .PC(PC), .FLUSH(FLUSH),
        .MISALIGNED_INSTR(MISALIGNED_INSTR), .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the fetch rules to the inputs sampled at this edge.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        take;
        if (!RESET) begin
            m_booting = 1'b1;
            m_iaddr   = BOOT;
            m_pc      = 32'h0;
            m_flush   = 1'b1;
            m_mis     = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_mis     = 1'b0;
        end else begin
            tgt = IADDER_OUT;
            if (OPCODE_6_TO_2 == JALR && tgt % 2 == 1) tgt = tgt - 1;
            take  = BRANCH_TAKEN && !m_flush && !PC_STALL;
            m_mis = 1'b0;
            if (TRAP_TAKEN) begin
                m_iaddr = TRAP_ADDRESS - (TRAP_ADDRESS % 4);
                m_flush = 1'b1;
            end else if (take && (tgt % 4) < 2) begin
                m_iaddr = tgt - (tgt % 4);
                m_flush = 1'b1;
            end else begin
                if (take) m_mis = 1'b1;
                if (I_READY && !PC_STALL) begin
                    m_pc    = m_iaddr;
                    m_iaddr = m_iaddr + 32'd4;
                    m_flush = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("i_addr", I_ADDR, m_iaddr);
        check("pc", PC, m_pc);
        check("flush", {31'b0, FLUSH}, {31'b0, m_flush});
        check("misaligned", {31'b0, MISALIGNED_INSTR}, {31'b0, m_mis});
        check("i_req", {31'b0, I_REQ}, {31'b0, !m_booting});
        check("i_addr_align", {30'b0, I_ADDR[1:0]}, 32'h0);
    endtask

    task automatic idle_inputs();
        BRANCH_TAKEN  = 1'b0;
        OPCODE_6_TO_2 = 5'b11000;
        IADDER_OUT    = 32'h0;
        TRAP_TAKEN    = 1'b0;
        TRAP_ADDRESS  = 32'h0;
        PC_STALL      = 1'b0;
        I_READY       = 1'b1;
    endtask

    initial begin
        m_booting = 1'b1;
        m_iaddr   = BOOT;
        m_pc      = 32'h0;
        m_flush   = 1'b1;
        m_mis     = 1'b0;
        RESET     = 1'b0;
        idle_inputs();

        // Reset and boot
        step();
        step();
        check("rst_iaddr", I_ADDR, 32'h100);
        check("rst_pc", PC, 32'h0);
        check("rst_flush", {31'b0, FLUSH}, 32'h1);
        check("rst_ireq", {31'b0, I_REQ}, 32'h0);
        RESET = 1'b1;
        step();
        check("boot_iaddr", I_ADDR, 32'h100);
        check("boot_ireq", {31'b0, I_REQ}, 32'h1);
        step();
        check("first_pc", PC, 32'h100);
        check("first_flush", {31'b0, FLUSH}, 32'h0);
        step();
        step();
        check("seq_pc", PC, 32'h108);
        check("seq_iaddr", I_ADDR, 32'h10C);

        // Taken branch from PC=0x108
        BRANCH_TAKEN = 1'b1;
        IADDER_OUT   = 32'h200;
        step();
        check("br_iaddr", I_ADDR, 32'h200);
        check("br_flush", {31'b0, FLUSH}, 32'h1);
        BRANCH_TAKEN = 1'b0;
        step();
        check("br_pc", PC, 32'h200);
        check("br_flush_clear", {31'b0, FLUSH}, 32'h0);

        // JALR: LSB cleared, then a misaligned target
        BRANCH_TAKEN  = 1'b1;
        OPCODE_6_TO_2 = JALR;
        IADDER_OUT    = 32'h301;
        step();
        check("jalr_iaddr", I_ADDR, 32'h300);
        check("jalr_mis", {31'b0, MISALIGNED_INSTR}, 32'h0);
        BRANCH_TAKEN = 1'b0;
        step();
        BRANCH_TAKEN = 1'b1;
        IADDER_OUT   = 32'h302;
        step();
        check("mis_raised", {31'b0, MISALIGNED_INSTR}, 32'h1);
        check("mis_iaddr", I_ADDR, 32'h308);
        BRANCH_TAKEN = 1'b0;
        step();
        check("mis_one_cycle", {31'b0, MISALIGNED_INSTR}, 32'h0);

        // Stall three cycles with a branch request, then two not-ready cycles
        PC_STALL      = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        OPCODE_6_TO_2 = 5'b11000;
        IADDER_OUT    = 32'h500;
        repeat (3) step();
        BRANCH_TAKEN = 1'b0;
        PC_STALL     = 1'b0;
        I_READY      = 1'b0;
        repeat (2) step();
        check("stall_pc", PC, 32'h308);
        check("stall_iaddr", I_ADDR, 32'h30C);
        I_READY = 1'b1;
        step();
        check("resume_iaddr", I_ADDR, 32'h310);

        // Trap beats a branch, even while stalled
        TRAP_TAKEN   = 1'b1;
        TRAP_ADDRESS = 32'h80;
        BRANCH_TAKEN = 1'b1;
        IADDER_OUT   = 32'h400;
        PC_STALL     = 1'b1;
        step();
        check("trap_iaddr", I_ADDR, 32'h80);
        check("trap_flush", {31'b0, FLUSH}, 32'h1);
        check("trap_mis", {31'b0, MISALIGNED_INSTR}, 32'h0);
        idle_inputs();
        step();
        check("trap_pc", PC, 32'h80);

        // Address wrap, then reset in the middle of a hold
        TRAP_TAKEN   = 1'b1;
        TRAP_ADDRESS = 32'hFFFF_FFFE;
        step();
        check("wrap_setup", I_ADDR, 32'hFFFF_FFFC);
        TRAP_TAKEN = 1'b0;
        step();
        check("wrap_iaddr", I_ADDR, 32'h0);
        check("wrap_pc", PC, 32'hFFFF_FFFC);
        PC_STALL = 1'b1;
        step();
        RESET = 1'b0;
        step();
        check("midhold_rst_iaddr", I_ADDR, 32'h100);
        check("midhold_rst_pc", PC, 32'h0);
        check("midhold_rst_ireq", {31'b0, I_REQ}, 32'h0);
        RESET = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RESET         = ($urandom_range(0, 99) != 0);
            BRANCH_TAKEN  = ($urandom_range(0, 3) == 0);
            OPCODE_6_TO_2 = ($urandom_range(0, 1) == 0) ? JALR : 5'($urandom());
            IADDER_OUT    = $urandom();
            TRAP_TAKEN    = ($urandom_range(0, 15) == 0);
            TRAP_ADDRESS  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            PC_STALL      = ($urandom_range(0, 4) == 0);
            I_READY       = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
